// File: rtl/rr_grant_arbiter_8_pkg.sv
// Shared types and constants for the 8-way round-robin grant arbiter.
// Imported by the interface, the rr_pick8 search and the arbiter top.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  // Last-owner pointer after reset; requester 0 is searched first.
  localparam logic [IDX_W-1:0] PTR_RST = 3'd7;

  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_8_if.sv
// Requester-side bundle of the arbiter: request vector in, grant outputs back.
// The master modport is the requester side; the slave modport is the arbiter.
interface rr_grant_arbiter_8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             busy;
  logic             timeout;

  modport master (
    output req,
    input  grant, grant_idx, grant_valid, busy, timeout
  );

  modport slave (
    input  req,
    output grant, grant_idx, grant_valid, busy, timeout
  );

endinterface

// File: rtl/rr_grant_arbiter_8_pick8.sv
// Combinational rotate-priority search: first set request bit scanning
// upward from ptr+1, wrapping round so that ptr itself is checked last.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    w_cand  = '0;
    // k = N_REQ wraps to ptr itself, so the last owner has the lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = ptr + IDX_W'(k);
      if (!win_any && req[w_cand]) begin
        win_any = 1'b1;
        win_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter_8.sv
// 8-way round-robin arbiter with a registered one-hot grant held until the owner
// drops its request. Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles.
//   state     | meaning
//   ARB_IDLE  | no owner; arbitrate the sampled request vector
//   ARB_GRANT | owner holds the grant until its request drops (or times out)
module rr_grant_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_grant_arbiter_8_if.slave bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must lie in 2..255");
  end

  arb_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [N_REQ-1:0] r_grant;
  logic             r_valid;
  logic             r_busy;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_any;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]       r_hold, w_hold_nxt;
  logic             r_timeout, w_timeout_nxt;
`endif

  rr_pick8 u_pick (
    .req     (bus.req),
    .ptr     (r_ptr),
    .win_idx (w_win_idx),
    .win_any (w_win_any)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_idx_nxt     = r_idx;
`ifdef ARB_TIMEOUT_EN
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_win_any) begin
          w_state_nxt = ARB_GRANT;
          w_idx_nxt   = w_win_idx;
`ifdef ARB_TIMEOUT_EN
          w_hold_nxt  = 8'd1;
`endif
        end
      end
      ARB_GRANT: begin
        if (!bus.req[r_idx]) begin
          w_state_nxt = ARB_IDLE;
          w_ptr_nxt   = r_idx;
          w_idx_nxt   = '0;
`ifdef ARB_TIMEOUT_EN
          w_hold_nxt  = '0;
        end else if (r_hold >= 8'(MAX_HOLD)) begin
          // A request drop in the same cycle takes the branch above: no timeout.
          w_state_nxt   = ARB_IDLE;
          w_ptr_nxt     = r_idx;
          w_idx_nxt     = '0;
          w_hold_nxt    = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_nxt    = r_hold + 8'd1;
`endif
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_ptr   <= PTR_RST;
      r_idx   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_grant <= (w_state_nxt == ARB_GRANT) ? onehot8(w_idx_nxt) : '0;
      r_valid <= (w_state_nxt == ARB_GRANT);
      r_busy  <= (w_state_nxt == ARB_GRANT);
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant       = r_grant;
  assign bus.grant_idx   = r_idx;
  assign bus.grant_valid = r_valid;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_rr_grant_arbiter_8.sv
// Bench for rr_grant_arbiter_8: directed scenarios plus random requests checked
// against a cycle-level owner/pointer reference model.
module tb_rr_grant_arbiter_8;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Reference model: current owner (-1 = none), last owner, hold length, pulse.
  int   m_owner;
  int   m_ptr;
  int   m_hold;
  bit   m_to;

  rr_grant_arbiter_8_if bus ();

  rr_grant_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_step(input logic [7:0] r, input logic rst);
    if (!rst) begin
      m_owner = -1;
      m_ptr   = 7;
      m_hold  = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= 8; k++) begin
          if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            m_hold  = 1;
          end
        end
      end else if (!r[m_owner]) begin
        m_ptr   = m_owner;
        m_owner = -1;
      end else if (TIMEOUT_ON && m_hold >= MAX_HOLD) begin
        m_ptr   = m_owner;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_hold++;
      end
    end
  endfunction

  // {grant, idx, valid, busy, timeout}; idx only meaningful while valid.
  function automatic logic [13:0] exp_vec();
    logic [7:0] g;
    logic [2:0] ix;
    g  = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    ix = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    return {g, ix, (m_owner >= 0), (m_owner >= 0), m_to};
  endfunction

  function automatic logic [13:0] act_vec();
    return {bus.grant, bus.grant_idx & {3{bus.grant_valid}}, bus.grant_valid,
            bus.busy, bus.timeout};
  endfunction

  task automatic cycle(input logic [7:0] r, input logic rst);
    bus.req = r;
    rst_n   = rst;
    @(posedge clk);
    model_step(r, rst);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(8'hFF, 1'b0);
    total++;
    if ({bus.grant, bus.grant_idx, bus.grant_valid, bus.busy, bus.timeout} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {bus.grant, bus.grant_idx, bus.grant_valid, bus.busy, bus.timeout});
    end
  endtask

  task automatic test_idle();
    cycle(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(8'h00, 1'b1);
      total++;
      if ({bus.grant, bus.grant_valid, bus.busy} !== 10'd0) begin
        bad++;
        $display("FAIL idle_zero cycle %0d: got grant=%h valid=%b busy=%b expected 00/0/0",
                 i, bus.grant, bus.grant_valid, bus.busy);
      end
    end
  endtask

  task automatic test_two_req();
    logic [7:0] want [4] = '{8'h01, 8'h01, 8'h00, 8'h80};
    logic [7:0] reqs [4] = '{8'h81, 8'h81, 8'h80, 8'h80};
    cycle(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(reqs[i], 1'b1);
      total++;
      if (bus.grant !== want[i] || act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL two_req step %0d: got grant=%h vec=%h expected grant=%h vec=%h",
                 i, bus.grant, act_vec(), want[i], exp_vec());
      end
    end
    total++;
    if (bus.grant_idx !== 3'd7) begin
      bad++;
      $display("FAIL two_req_idx: got %0d expected 7", bus.grant_idx);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] g;
    cycle(8'h00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      g = 8'(1 << (i % 8));
      for (int c = 0; c < 3; c++) begin
        cycle(8'hFF, 1'b1);
        total++;
        if (bus.grant !== g || bus.grant_idx !== 3'(i % 8) || bus.timeout !== 1'b0) begin
          bad++;
          $display("FAIL rotation owner %0d cycle %0d: got grant=%h idx=%0d to=%b expected %h/%0d/0",
                   i % 8, c, bus.grant, bus.grant_idx, bus.timeout, g, i % 8);
        end
      end
      cycle(8'hFF & ~g, 1'b1);
      total++;
      if (bus.grant !== 8'h00 || bus.grant_valid !== 1'b0) begin
        bad++;
        $display("FAIL rotation_gap after %0d: got grant=%h valid=%b expected 00/0",
                 i % 8, bus.grant, bus.grant_valid);
      end
    end
  endtask

  task automatic test_no_preempt();
    logic [7:0] reqs [6] = '{8'h08, 8'h28, 8'h28, 8'h20, 8'h20, 8'h00};
    logic [7:0] want [6] = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h20, 8'h00};
    cycle(8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(reqs[i], 1'b1);
      total++;
      if (bus.grant !== want[i]) begin
        bad++;
        $display("FAIL no_preempt step %0d: got grant=%h expected %h", i, bus.grant, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(8'h00, 1'b0);
    cycle(8'h10, 1'b1);
    total++;
    if (bus.grant !== 8'h10) begin
      bad++;
      $display("FAIL reset_mid_setup: got grant=%h expected 10", bus.grant);
    end
    cycle(8'h10, 1'b0);
    total++;
    if ({bus.grant, bus.grant_idx, bus.grant_valid, bus.busy, bus.timeout} !== 14'd0) begin
      bad++;
      $display("FAIL reset_mid_clear: got %h expected 0000",
               {bus.grant, bus.grant_idx, bus.grant_valid, bus.busy, bus.timeout});
    end
    cycle(8'h11, 1'b1);
    total++;
    if (bus.grant !== 8'h01 || bus.grant_idx !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid_ptr: got grant=%h idx=%0d expected 01/0", bus.grant, bus.grant_idx);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    // Forced release, next owner, then a drop coinciding with the limit.
    logic [7:0] reqs [13] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h01,
                              8'h03, 8'h03, 8'h03, 8'h03, 8'h02, 8'h02};
    logic [7:0] want [13] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h00,
                              8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02};
    logic       wto  [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    cycle(8'h00, 1'b0);
    for (int i = 0; i < 13; i++) begin
      cycle(reqs[i], 1'b1);
      total++;
      if (bus.grant !== want[i] || bus.timeout !== wto[i]) begin
        bad++;
        $display("FAIL timeout step %0d: got grant=%h to=%b expected %h/%b",
                 i, bus.grant, bus.timeout, want[i], wto[i]);
      end
    end
  endtask
`else
  task automatic test_hold_forever();
    cycle(8'h00, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(8'h03, 1'b1);
      total++;
      if (bus.grant !== 8'h01 || bus.timeout !== 1'b0) begin
        bad++;
        $display("FAIL hold_forever cycle %0d: got grant=%h to=%b expected 01/0",
                 i, bus.grant, bus.timeout);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] r;
    logic       rst;
    cycle(8'h00, 1'b0);
    for (int i = 0; i < 600; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      if (m_owner >= 0 && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
      rst = ($urandom_range(0, 79) != 0);
      cycle(r, rst);
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random cycle %0d req=%h: got %h expected %h", i, r, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    m_owner = -1;
    m_ptr   = 7;
    m_hold  = 0;
    m_to    = 1'b0;
    rst_n   = 1'b0;
    bus.req = 8'h00;
    @(negedge clk);
    test_reset();
    test_idle();
    test_two_req();
    test_rotation();
    test_no_preempt();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold_forever();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
